// File: rtl/systolic_os_array_pkg.sv
// rtl/systolic_os_array_pkg.sv - shared types and helpers for the output-stationary systolic array
// Contents:
//   state_t      : job FSM states
//   SAT_W        : working width of the saturation helper
//   idx_bits()   : index width for a count, never below 1
//   flush_cycles(): zero-injection cycles needed to push the last operand through the grid
//   sat_to_data(): clamp a sign-extended accumulator to a data_bits-wide signed range
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int SAT_W = 64;

    function automatic int idx_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // The operand pair entering on the last beat reaches PE(ROWS-1,COLS-1)
    // ROWS+COLS-2 advances later; one spare advance keeps the count simple.
    function automatic int flush_cycles(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_to_data(
        input logic signed [SAT_W-1:0] acc,
        input int unsigned             data_bits
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (data_bits - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        if (acc > hi) begin
            return hi;
        end
        if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/systolic_os_array_if.sv
// rtl/systolic_os_array_if.sv - job control, operand stream and result stream bundle
// master: tile fetch / writeback side (drives start, k_len, operands, res_ready)
// slave : the array (drives busy, done, in_ready, results, sat_flag)
interface systolic_os_array_if #(
    parameter int DATA_BITS = 16,
    parameter int K_BITS    = 8,
    parameter int ROWS      = 8,
    parameter int COLS      = 8
);
    import systolic_pkg::*;

    localparam int ROW_W = idx_bits(ROWS);

    logic                      start;
    logic [K_BITS-1:0]         k_len;
    logic                      busy;
    logic                      done;
    logic                      in_valid;
    logic                      in_ready;
    logic [ROWS*DATA_BITS-1:0] a_in;
    logic [COLS*DATA_BITS-1:0] b_in;
    logic                      res_valid;
    logic                      res_ready;
    logic [ROW_W-1:0]          res_row;
    logic [COLS*DATA_BITS-1:0] res_data;
    logic                      sat_flag;

    modport master (
        output start, k_len, in_valid, a_in, b_in, res_ready,
        input  busy, done, in_ready, res_valid, res_row, res_data, sat_flag
    );

    modport slave (
        input  start, k_len, in_valid, a_in, b_in, res_ready,
        output busy, done, in_ready, res_valid, res_row, res_data, sat_flag
    );

endinterface

// File: rtl/systolic_os_array_pe.sv
// rtl/systolic_os_array_pe.sv - one output-stationary processing element
// Ports:
//   clk, reset       : clock, async active-high reset
//   clear            : zero pass registers and accumulator (job start)
//   advance          : take one array step (shift operands, MAC)
//   a_left / b_top   : operands arriving from the left / above
//   a_right / b_down : registered operands forwarded right / down
//   acc              : running accumulator
module systolic_os_pe #(
    parameter int DATA_BITS = 16,
    parameter int FRAC_BITS = 15,
    parameter int ACC_BITS  = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        advance,
    input  logic signed [DATA_BITS-1:0] a_left,
    input  logic signed [DATA_BITS-1:0] b_top,
    output logic signed [DATA_BITS-1:0] a_right,
    output logic signed [DATA_BITS-1:0] b_down,
    output logic signed [ACC_BITS-1:0]  acc
);
    localparam int PROD_W = 2 * DATA_BITS;
    localparam int EXT_W  = (ACC_BITS > PROD_W) ? ACC_BITS : PROD_W;

    logic signed [DATA_BITS-1:0] a_q, a_d;
    logic signed [DATA_BITS-1:0] b_q, b_d;
    logic signed [ACC_BITS-1:0]  acc_q, acc_d;
    logic signed [PROD_W-1:0]    prod;
    logic signed [EXT_W-1:0]     prod_ext;
    logic signed [ACC_BITS-1:0]  addend;

    always_comb begin
        prod     = PROD_W'(a_left) * PROD_W'(b_top);
        prod_ext = EXT_W'(prod);
        // Arithmetic shift floors toward -inf; upper bits beyond ACC_BITS wrap.
        addend   = ACC_BITS'(prod_ext >>> FRAC_BITS);
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        if (clear) begin
            a_d   = '0;
            b_d   = '0;
            acc_d = '0;
        end else if (advance) begin
            a_d   = a_left;
            b_d   = b_top;
            acc_d = acc_q + addend;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_right = a_q;
    assign b_down  = b_q;
    assign acc     = acc_q;

endmodule

// File: rtl/systolic_os_array.sv
// rtl/systolic_os_array.sv - output-stationary systolic engine computing C = A * B in signed fixed point
// Ports:
//   clk, reset : clock, async active-high reset
//   io (slave) : start/k_len/busy/done job control; in_valid/in_ready/a_in/b_in operand
//                beats; res_valid/res_ready/res_row/res_data row drain; sticky sat_flag
module systolic_os_array
    import systolic_pkg::*;
#(
    parameter int DATA_BITS = 16,
    parameter int FRAC_BITS = 15,
    parameter int ACC_BITS  = 24,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int K_BITS    = 8
) (
    input logic clk,
    input logic reset,
    systolic_os_array_if.slave io
);
    localparam int ROW_W        = idx_bits(ROWS);
    localparam int FLUSH_CYCLES = flush_cycles(ROWS, COLS);
    localparam int FLUSH_W      = $clog2(FLUSH_CYCLES + 1);

    state_t               state_q, state_d;
    logic [K_BITS-1:0]    cnt_q, cnt_d;
    logic [FLUSH_W-1:0]   flush_q, flush_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 sat_q, sat_d;
    logic                 done_q, done_d;

    logic busy, in_ready, res_valid;
    logic clear, advance, fire, accept, last_row, row_sat;
    logic [COLS*DATA_BITS-1:0] row_data;

    logic signed [DATA_BITS-1:0] a_edge [ROWS];
    logic signed [DATA_BITS-1:0] b_edge [COLS];
    logic signed [DATA_BITS-1:0] a_pass [ROWS][COLS];
    logic signed [DATA_BITS-1:0] b_pass [ROWS][COLS];
    logic signed [ACC_BITS-1:0]  acc    [ROWS][COLS];

    assign last_row = (row_q == ROW_W'(ROWS - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (io.start) state_d = (io.k_len == '0) ? DRAIN : STREAM;
            STREAM: if (fire && cnt_q == K_BITS'(1)) state_d = FLUSH;
            FLUSH:  if (flush_q == '0) state_d = DRAIN;
            DRAIN:  if (accept && last_row) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        in_ready  = (state_q == STREAM);
        res_valid = (state_q == DRAIN);
        clear     = (state_q == IDLE) && io.start;
        fire      = in_ready && io.in_valid;
        accept    = res_valid && io.res_ready;
        // A stalled stream freezes the whole grid; flush steps unconditionally.
        advance   = fire || (state_q == FLUSH);
    end

    // ---------------- counters and flags ----------------
    always_comb begin
        cnt_d   = cnt_q;
        flush_d = flush_q;
        row_d   = row_q;
        sat_d   = sat_q;
        done_d  = 1'b0;
        if (clear) begin
            cnt_d   = io.k_len;
            flush_d = FLUSH_W'(FLUSH_CYCLES - 1);
            row_d   = '0;
            sat_d   = 1'b0;
        end
        if (fire) begin
            cnt_d = cnt_q - K_BITS'(1);
        end
        if (state_q == FLUSH && flush_q != '0) begin
            flush_d = flush_q - FLUSH_W'(1);
        end
        if (accept) begin
            sat_d = sat_q | row_sat;
            if (last_row) begin
                row_d  = '0;
                done_d = 1'b1;
            end else begin
                row_d = row_q + ROW_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            flush_q <= '0;
            row_q   <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            row_q   <= row_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    // ---------------- input skew: row i delayed by i advances ----------------
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_skew
        logic signed [DATA_BITS-1:0] a_src;
        assign a_src = (state_q == FLUSH) ? '0 : io.a_in[gi*DATA_BITS +: DATA_BITS];
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = a_src;
        end else begin : g_line
            logic signed [DATA_BITS-1:0] line_q [gi];
            logic signed [DATA_BITS-1:0] line_d [gi];
            always_comb begin
                line_d = line_q;
                if (clear) begin
                    for (int n = 0; n < gi; n++) line_d[n] = '0;
                end else if (advance) begin
                    line_d[0] = a_src;
                    for (int n = 1; n < gi; n++) line_d[n] = line_q[n-1];
                end
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    line_q <= '{default: '0};
                end else begin
                    line_q <= line_d;
                end
            end
            assign a_edge[gi] = line_q[gi-1];
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_b_skew
        logic signed [DATA_BITS-1:0] b_src;
        assign b_src = (state_q == FLUSH) ? '0 : io.b_in[gj*DATA_BITS +: DATA_BITS];
        if (gj == 0) begin : g_direct
            assign b_edge[gj] = b_src;
        end else begin : g_line
            logic signed [DATA_BITS-1:0] line_q [gj];
            logic signed [DATA_BITS-1:0] line_d [gj];
            always_comb begin
                line_d = line_q;
                if (clear) begin
                    for (int n = 0; n < gj; n++) line_d[n] = '0;
                end else if (advance) begin
                    line_d[0] = b_src;
                    for (int n = 1; n < gj; n++) line_d[n] = line_q[n-1];
                end
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    line_q <= '{default: '0};
                end else begin
                    line_q <= line_d;
                end
            end
            assign b_edge[gj] = line_q[gj-1];
        end
    end

    // ---------------- PE grid ----------------
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            logic signed [DATA_BITS-1:0] a_left;
            logic signed [DATA_BITS-1:0] b_top;
            if (gj == 0) begin : g_a_edge
                assign a_left = a_edge[gi];
            end else begin : g_a_int
                assign a_left = a_pass[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_top = b_edge[gj];
            end else begin : g_b_int
                assign b_top = b_pass[gi-1][gj];
            end
            systolic_os_pe #(
                .DATA_BITS(DATA_BITS),
                .FRAC_BITS(FRAC_BITS),
                .ACC_BITS (ACC_BITS)
            ) u_pe (
                .clk    (clk),
                .reset  (reset),
                .clear  (clear),
                .advance(advance),
                .a_left (a_left),
                .b_top  (b_top),
                .a_right(a_pass[gi][gj]),
                .b_down (b_pass[gi][gj]),
                .acc    (acc[gi][gj])
            );
        end
    end

    // ---------------- drain mux and saturation ----------------
    always_comb begin
        row_data = '0;
        row_sat  = 1'b0;
        for (int j = 0; j < COLS; j++) begin
            row_data[j*DATA_BITS +: DATA_BITS] =
                DATA_BITS'(sat_to_data(SAT_W'(acc[row_q][j]), DATA_BITS));
            if (sat_to_data(SAT_W'(acc[row_q][j]), DATA_BITS) != SAT_W'(acc[row_q][j])) begin
                row_sat = 1'b1;
            end
        end
    end

    assign io.busy      = busy;
    assign io.done      = done_q;
    assign io.in_ready  = in_ready;
    assign io.res_valid = res_valid;
    assign io.res_row   = row_q;
    assign io.res_data  = res_valid ? row_data : '0;
    assign io.sat_flag  = sat_q;

endmodule

// File: tb/tb_systolic_os_array.sv
// tb/tb_systolic_os_array.sv - scoreboard bench for systolic_os_array (4x4 and 2x3 instances)
module tb_systolic_os_array;
    localparam int DW = 16;
    localparam int FB = 15;
    localparam int AW = 24;
    localparam int KB = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    systolic_os_array_if #(.DATA_BITS(DW), .K_BITS(KB), .ROWS(4), .COLS(4)) io4 ();
    systolic_os_array_if #(.DATA_BITS(DW), .K_BITS(KB), .ROWS(2), .COLS(3)) io23 ();

    systolic_os_array #(.DATA_BITS(DW), .FRAC_BITS(FB), .ACC_BITS(AW),
                        .ROWS(4), .COLS(4), .K_BITS(KB))
        dut4 (.clk(clk), .reset(reset), .io(io4.slave));

    systolic_os_array #(.DATA_BITS(DW), .FRAC_BITS(FB), .ACC_BITS(AW),
                        .ROWS(2), .COLS(3), .K_BITS(KB))
        dut23 (.clk(clk), .reset(reset), .io(io23.slave));

    int checks   = 0;
    int failures = 0;
    int tmo      = 0;
    int unstable = 0;

    logic signed [15:0] a_m [4][8];
    logic signed [15:0] b_m [8][4];

    logic [63:0] exp_data_q [$];
    int          exp_row_q  [$];
    logic [63:0] obs_data_q [$];
    int          obs_row_q  [$];
    bit          exp_sat;
    logic        done_pulse, done_after, busy_after, sat_obs;

    // Q1.15 reference: floor each product, wrap the sum to AW bits, clamp.
    function automatic logic [15:0] model_c(input int i, input int j, input int kl, output bit sat);
        longint acc = 0;
        longint p;
        for (int k = 0; k < kl; k++) begin
            p   = longint'(a_m[i][k]) * longint'(b_m[k][j]);
            acc = acc + (p >>> FB);
        end
        acc = (acc <<< (64 - AW)) >>> (64 - AW);
        sat = 1'b0;
        if (acc > 32767) begin
            sat = 1'b1;
            acc = 32767;
        end else if (acc < -32768) begin
            sat = 1'b1;
            acc = -32768;
        end
        return acc[15:0];
    endfunction

    task automatic push_expected(input int rows, input int cols, input int kl);
        logic [63:0] row;
        bit s;
        exp_sat = 1'b0;
        exp_data_q.delete();
        exp_row_q.delete();
        obs_data_q.delete();
        obs_row_q.delete();
        for (int i = 0; i < rows; i++) begin
            row = '0;
            for (int j = 0; j < cols; j++) begin
                row[j*16 +: 16] = model_c(i, j, kl, s);
                exp_sat |= s;
            end
            exp_data_q.push_back(row);
            exp_row_q.push_back(i);
        end
    endtask

    task automatic start4(input int kl);
        @(negedge clk);
        io4.k_len = kl[KB-1:0];
        io4.start = 1'b1;
        @(negedge clk);
        io4.start = 1'b0;
    endtask

    task automatic stream4(input int kl, input bit gaps);
        int w;
        for (int k = 0; k < kl; k++) begin
            if (gaps && k > 0) begin
                io4.in_valid = 1'b0;
                io4.a_in     = {$urandom, $urandom};
                io4.b_in     = {$urandom, $urandom};
                @(negedge clk);
            end
            w = 0;
            while (!io4.in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) tmo++;
            for (int i = 0; i < 4; i++) io4.a_in[i*DW +: DW] = a_m[i][k];
            for (int j = 0; j < 4; j++) io4.b_in[j*DW +: DW] = b_m[k][j];
            io4.in_valid = 1'b1;
            @(negedge clk);
        end
        io4.in_valid = 1'b0;
    endtask

    task automatic drain4(input int stall, input bit poke);
        int w;
        logic [63:0] d0;
        int r0;
        for (int r = 0; r < 4; r++) begin
            w = 0;
            while (!io4.res_valid && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) tmo++;
            d0 = 64'(io4.res_data);
            r0 = int'(io4.res_row);
            for (int s = 0; s < stall; s++) begin
                io4.res_ready = 1'b0;
                if (poke && r == 1 && s == 0) begin
                    io4.start = 1'b1;
                    io4.k_len = 8'd5;
                end
                @(negedge clk);
                io4.start = 1'b0;
                if (64'(io4.res_data) !== d0 || int'(io4.res_row) !== r0 || io4.res_valid !== 1'b1)
                    unstable++;
            end
            io4.res_ready = 1'b1;
            obs_data_q.push_back(64'(io4.res_data));
            obs_row_q.push_back(int'(io4.res_row));
            @(negedge clk);
            io4.res_ready = 1'b0;
        end
        done_pulse = io4.done;
        busy_after = io4.busy;
        sat_obs    = io4.sat_flag;
        @(negedge clk);
        done_after = io4.done;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({io4.busy, io4.done, io4.in_ready, io4.res_valid, io4.sat_flag} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags4: got %b required 00000",
                     {io4.busy, io4.done, io4.in_ready, io4.res_valid, io4.sat_flag});
        end
        checks++;
        if (io4.res_data !== '0 || io4.res_row !== '0) begin
            failures++;
            $display("FAIL reset_data4: got row %0d data %h required 0", io4.res_row, io4.res_data);
        end
        checks++;
        if ({io23.busy, io23.in_ready, io23.res_valid, io23.sat_flag} !== 4'b0 || io23.res_data !== '0) begin
            failures++;
            $display("FAIL reset_23: got flags %b data %h required 0",
                     {io23.busy, io23.in_ready, io23.res_valid, io23.sat_flag}, io23.res_data);
        end
    endtask

    task automatic test_identity();
        int fc, bad;
        logic [63:0] od;
        int orow;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) a_m[i][k] = (i == k) ? 16'sh7FFF : 16'sh0000;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) b_m[k][j] = 16'(16'h1000 * (k + 1));
        push_expected(4, 4, 4);
        start4(4);
        stream4(4, 1'b0);
        fc  = 0;
        bad = 0;
        while (!io4.res_valid && fc < 50) begin
            if (io4.in_ready) bad++;
            fc++;
            @(negedge clk);
        end
        checks++;
        if (fc !== 7) begin
            failures++;
            $display("FAIL identity_flush_len: got %0d cycles required 7", fc);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL identity_flush_ready: got %0d in_ready cycles required 0", bad);
        end
        drain4(0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            od   = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 64'hx;
            orow = (obs_row_q.size() > 0) ? obs_row_q.pop_front() : -1;
            checks++;
            if (od !== exp_data_q[r] || orow !== exp_row_q[r]) begin
                failures++;
                $display("FAIL identity_row%0d: got row %0d %h required row %0d %h",
                         r, orow, od, exp_row_q[r], exp_data_q[r]);
            end
        end
        checks++;
        if (sat_obs !== exp_sat) begin
            failures++;
            $display("FAIL identity_sat: got %b required %b", sat_obs, exp_sat);
        end
        checks++;
        if ({done_pulse, done_after, busy_after} !== 3'b100) begin
            failures++;
            $display("FAIL identity_done: got done/next/busy %b required 100",
                     {done_pulse, done_after, busy_after});
        end
    endtask

    task automatic test_q_format();
        int          kl_t [3] = '{2, 4, 4};
        logic [15:0] a_t  [3] = '{16'h4000, 16'h4000, 16'hC000};
        logic [63:0] od;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++) begin
                    a_m[i][k] = a_t[c];
                    b_m[k][i] = 16'sh4000;
                end
            push_expected(4, 4, kl_t[c]);
            start4(kl_t[c]);
            stream4(kl_t[c], 1'b0);
            drain4(0, 1'b0);
            for (int r = 0; r < 4; r++) begin
                od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 64'hx;
                checks++;
                if (od !== exp_data_q[r]) begin
                    failures++;
                    $display("FAIL qfmt%0d_row%0d: got %h required %h", c, r, od, exp_data_q[r]);
                end
            end
            checks++;
            if (sat_obs !== exp_sat) begin
                failures++;
                $display("FAIL qfmt%0d_sat: got %b required %b", c, sat_obs, exp_sat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] od;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = 16'($urandom);
                b_m[k][i] = 16'($urandom);
            end
        for (int pass = 0; pass < 2; pass++) begin
            unstable = 0;
            push_expected(4, 4, 4);
            start4(4);
            stream4(4, pass == 1);
            drain4((pass == 1) ? 3 : 0, 1'b0);
            for (int r = 0; r < 4; r++) begin
                od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 64'hx;
                checks++;
                if (od !== exp_data_q[r]) begin
                    failures++;
                    $display("FAIL bp%0d_row%0d: got %h required %h", pass, r, od, exp_data_q[r]);
                end
            end
            checks++;
            if (sat_obs !== exp_sat) begin
                failures++;
                $display("FAIL bp%0d_sat: got %b required %b", pass, sat_obs, exp_sat);
            end
        end
        checks++;
        if (unstable !== 0) begin
            failures++;
            $display("FAIL bp_stable: got %0d unstable stall cycles required 0", unstable);
        end
    endtask

    task automatic test_non_square();
        int w;
        logic [63:0] od;
        int orow;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++) begin
                a_m[i][k] = 16'($urandom);
                b_m[k][i] = 16'($urandom);
            end
        push_expected(2, 3, 3);
        @(negedge clk);
        io23.k_len = 8'd3;
        io23.start = 1'b1;
        @(negedge clk);
        io23.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w = 0;
            while (!io23.in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) tmo++;
            for (int i = 0; i < 2; i++) io23.a_in[i*DW +: DW] = a_m[i][k];
            for (int j = 0; j < 3; j++) io23.b_in[j*DW +: DW] = b_m[k][j];
            io23.in_valid = 1'b1;
            @(negedge clk);
        end
        io23.in_valid = 1'b0;
        for (int r = 0; r < 2; r++) begin
            w = 0;
            while (!io23.res_valid && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) tmo++;
            io23.res_ready = 1'b1;
            obs_data_q.push_back(64'(io23.res_data));
            obs_row_q.push_back(int'(io23.res_row));
            @(negedge clk);
            io23.res_ready = 1'b0;
        end
        sat_obs    = io23.sat_flag;
        done_pulse = io23.done;
        for (int r = 0; r < 2; r++) begin
            od   = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 64'hx;
            orow = (obs_row_q.size() > 0) ? obs_row_q.pop_front() : -1;
            checks++;
            if (od !== exp_data_q[r] || orow !== exp_row_q[r]) begin
                failures++;
                $display("FAIL nonsq_row%0d: got row %0d %h required row %0d %h",
                         r, orow, od, exp_row_q[r], exp_data_q[r]);
            end
        end
        checks++;
        if (sat_obs !== exp_sat || done_pulse !== 1'b1) begin
            failures++;
            $display("FAIL nonsq_flags: got sat %b done %b required sat %b done 1",
                     sat_obs, done_pulse, exp_sat);
        end
    endtask

    task automatic test_zero_k();
        logic [63:0] od;
        push_expected(4, 4, 0);
        start4(0);
        checks++;
        if (io4.in_ready !== 1'b0 || io4.res_valid !== 1'b1) begin
            failures++;
            $display("FAIL zerok_state: got in_ready %b res_valid %b required 0 1",
                     io4.in_ready, io4.res_valid);
        end
        drain4(1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 64'hx;
            checks++;
            if (od !== exp_data_q[r]) begin
                failures++;
                $display("FAIL zerok_row%0d: got %h required %h", r, od, exp_data_q[r]);
            end
        end
        checks++;
        if (sat_obs !== 1'b0 || done_pulse !== 1'b1) begin
            failures++;
            $display("FAIL zerok_flags: got sat %b done %b required 0 1", sat_obs, done_pulse);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] od;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = 16'($urandom);
                b_m[k][i] = 16'($urandom);
            end
        start4(4);
        stream4(2, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if ({io4.busy, io4.done, io4.in_ready, io4.res_valid, io4.sat_flag} !== 5'b0
            || io4.res_data !== '0 || io4.res_row !== '0) begin
            failures++;
            $display("FAIL midreset_async: got flags %b data %h required 0",
                     {io4.busy, io4.done, io4.in_ready, io4.res_valid, io4.sat_flag}, io4.res_data);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = 16'($urandom_range(0, 16'h3FFF));
                b_m[k][i] = 16'($urandom_range(0, 16'h3FFF));
            end
        push_expected(4, 4, 4);
        start4(4);
        stream4(4, 1'b0);
        drain4(1, 1'b1);
        for (int r = 0; r < 4; r++) begin
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 64'hx;
            checks++;
            if (od !== exp_data_q[r]) begin
                failures++;
                $display("FAIL fresh_row%0d: got %h required %h", r, od, exp_data_q[r]);
            end
        end
        checks++;
        if (done_pulse !== 1'b1 || busy_after !== 1'b0 || sat_obs !== exp_sat) begin
            failures++;
            $display("FAIL fresh_flags: got done %b busy %b sat %b required 1 0 %b",
                     done_pulse, busy_after, sat_obs, exp_sat);
        end
    endtask

    initial begin
        reset = 1'b1;
        io4.start = 1'b0;  io4.k_len = '0;  io4.in_valid = 1'b0;
        io4.a_in = '0;     io4.b_in = '0;   io4.res_ready = 1'b0;
        io23.start = 1'b0; io23.k_len = '0; io23.in_valid = 1'b0;
        io23.a_in = '0;    io23.b_in = '0;  io23.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_identity();
        test_q_format();
        test_backpressure();
        test_non_square();
        test_zero_k();
        test_reset_mid();
        checks++;
        if (tmo !== 0) begin
            failures++;
            $display("FAIL timeouts: got %0d expired waits required 0", tmo);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
